// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring arbiter: FSM encoding, default sizes
// and the one-hot token rotation helper.
package ring_arb_pkg;

    localparam int N_DEF   = 16;
    localparam int IDW_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    // Rotate the low n bits of v left by one (bit n-1 wraps to bit 0).
    // Works on a wide container so callers of any width up to 64 can share it.
    function automatic logic [63:0] rotl1(input logic [63:0] v, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_arbiter_onehot_encoder.sv
// One-hot to binary encoder. Each output bit is the OR of every one-hot
// input whose index has that bit set; an all-zero input encodes to 0.
module onehot_encoder #(
    parameter int N   = 16,
    parameter int IDW = 4
) (
    input  logic [N-1:0]   oh,
    output logic [IDW-1:0] id
);

    // OR tree per output bit.
    always_comb begin
        id = '0;
        for (int b = 0; b < IDW; b++) begin
            for (int i = 0; i < N; i++) begin
                if (((i >> b) & 1) == 1) begin
                    id[b] = id[b] | oh[i];
                end
            end
        end
    end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter for N requesters with a rotating one-hot token,
// a per-grant hold budget with forced preemption, and a dead TURN cycle
// between successive owners.
//
// Handshake: a requester raises REQ[i] and keeps it high for as long as it
// wants the resource; GNT[i] high means it owns the resource this cycle.
// The owner ends its tenure by dropping REQ[i]; the grant then falls at the
// next edge. A grant can also be withdrawn by preemption (PREEMPT pulses the
// following cycle), in which case the requester must keep REQ[i] high to be
// considered again at a later IDLE evaluation.
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDW      = IDW_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [N-1:0]   REQ,
    output logic [N-1:0]   GNT,
    output logic           GNT_VLD,
    output logic [IDW-1:0] GNT_ID,
    output logic [N-1:0]   TOKEN,
    output logic           PREEMPT,
    output state_t         STATE
);

    // Counter is wide enough to hold MAX_HOLD itself (its saturation value).
    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    token_q, token_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pre_q, pre_d;
    logic            vld_q;
    logic [IDW-1:0]  id_q, id_d;

    logic [N-1:0]    masked;
    logic [N-1:0]    hi_pick;
    logic [N-1:0]    lo_pick;
    logic [N-1:0]    winner;
    logic            owner_req;
    logic            others_req;

    // Circular priority search: lowest set request at or above the token,
    // otherwise wrap to the lowest set request overall.
    always_comb begin
        masked  = REQ & ~(token_q - N'(1));
        hi_pick = masked & (~masked + N'(1));
        lo_pick = REQ & (~REQ + N'(1));
        winner  = (|masked) ? hi_pick : lo_pick;
    end

    // Next-state, grant, token, hold counter and preempt pulse.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        token_d    = token_q;
        cnt_d      = cnt_q;
        pre_d      = 1'b0;
        owner_req  = |(REQ & gnt_q);
        others_req = |(REQ & ~gnt_q);
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    gnt_d   = winner;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    // Normal release wins even if the budget also expires here.
                    gnt_d   = '0;
                    token_d = N'(rotl1(64'(gnt_q), N));
                    state_d = S_TURN;
                end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST) && others_req) begin
                    gnt_d   = '0;
                    token_d = N'(rotl1(64'(gnt_q), N));
                    pre_d   = 1'b1;
                    state_d = S_TURN;
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // The encoded id is taken from the next grant so it registers alongside GNT.
    onehot_encoder #(
        .N   (N),
        .IDW (IDW)
    ) u_enc (
        .oh (gnt_d),
        .id (id_d)
    );

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            token_q <= N'(1);
            cnt_q   <= '0;
            pre_q   <= 1'b0;
            vld_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            token_q <= token_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            vld_q   <= |gnt_d;
            id_q    <= id_d;
        end
    end

    assign GNT     = gnt_q;
    assign GNT_VLD = vld_q;
    assign GNT_ID  = id_q;
    assign TOKEN   = token_q;
    assign PREEMPT = pre_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Bench for ring_arbiter: two instances (hold budget 8 and budget disabled)
// share one request bus and are compared every cycle against an index-based
// behavioural model, plus directed scenario checks and a grant-order queue.
module tb_ring_arbiter;
  import ring_arb_pkg::*;

  logic        CLK;
  logic        rst_n;
  logic [15:0] req;

  logic [15:0] gnt8, tok8, gnt0, tok0;
  logic        vld8, pre8, vld0, pre0;
  logic [3:0]  id8, id0;
  state_t      st8, st0;

  int checks   = 0;
  int failures = 0;

  // model state per instance: 0 -> MAX_HOLD=8, 1 -> MAX_HOLD=0
  int m_owner[2];
  int m_tok[2];
  int m_turn[2];
  int m_held[2];
  int m_pre[2];

  logic [3:0] exp_q[$];
  bit         order_en = 0;
  logic       prev_vld0 = 0;

  ring_arbiter #(.N(16), .IDW(4), .MAX_HOLD(8)) dut8 (
    .CLK(CLK), .RST_N(rst_n), .REQ(req), .GNT(gnt8), .GNT_VLD(vld8),
    .GNT_ID(id8), .TOKEN(tok8), .PREEMPT(pre8), .STATE(st8)
  );

  ring_arbiter #(.N(16), .IDW(4), .MAX_HOLD(0)) dut0 (
    .CLK(CLK), .RST_N(rst_n), .REQ(req), .GNT(gnt0), .GNT_VLD(vld0),
    .GNT_ID(id0), .TOKEN(tok0), .PREEMPT(pre0), .STATE(st0)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [15:0] r, input logic rn);
    int mh;
    int o;
    bit others;
    mh = (k == 0) ? 8 : 0;
    if (!rn) begin
      m_owner[k] = -1; m_tok[k] = 0; m_turn[k] = 0; m_held[k] = 0; m_pre[k] = 0;
      return;
    end
    m_pre[k] = 0;
    if (m_turn[k] != 0) begin
      m_turn[k] = 0;
    end else if (m_owner[k] < 0) begin
      if (r != 16'h0) begin
        m_owner[k] = first_from(r, m_tok[k]);
        m_held[k]  = 1;
      end
    end else begin
      o = m_owner[k];
      others = (r & ~(16'h1 << o)) != 16'h0;
      if (!r[o]) begin
        m_tok[k] = (o + 1) % 16; m_owner[k] = -1; m_turn[k] = 1;
      end else if (mh != 0 && m_held[k] == mh && others) begin
        m_tok[k] = (o + 1) % 16; m_owner[k] = -1; m_turn[k] = 1; m_pre[k] = 1;
      end else if (m_held[k] < 1000) begin
        m_held[k]++;
      end
    end
  endtask

  task automatic check_dut(input int k, input logic [15:0] g, input logic v,
                           input logic [3:0] id, input logic [15:0] t,
                           input logic p, input state_t s);
    logic [15:0] eg;
    state_t      es;
    eg = (m_owner[k] >= 0) ? (16'h1 << m_owner[k]) : 16'h0;
    es = (m_turn[k] != 0) ? S_TURN : ((m_owner[k] >= 0) ? S_GRANT : S_IDLE);
    check($sformatf("gnt[%0d]", k), 32'(g), 32'(eg));
    check($sformatf("vld[%0d]", k), 32'(v), 32'(m_owner[k] >= 0));
    check($sformatf("id[%0d]", k), 32'(id), (m_owner[k] >= 0) ? 32'(m_owner[k]) : 32'd0);
    check($sformatf("token[%0d]", k), 32'(t), 32'(16'h1 << m_tok[k]));
    check($sformatf("preempt[%0d]", k), 32'(p), 32'(m_pre[k]));
    check($sformatf("state[%0d]", k), 32'(s), 32'(es));
  endtask

  // one clock: model advances on the edge, DUTs checked on the falling edge
  task automatic tick();
    @(posedge CLK);
    model_step(0, req, rst_n);
    model_step(1, req, rst_n);
    @(negedge CLK);
    check_dut(0, gnt8, vld8, id8, tok8, pre8, st8);
    check_dut(1, gnt0, vld0, id0, tok0, pre0, st0);
    if (order_en && vld0 && !prev_vld0 && exp_q.size() > 0) begin
      check("order", 32'(id0), 32'(exp_q.pop_front()));
    end
    prev_vld0 = vld0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    int cnt2, npre;
    logic [15:0] base, drop;
    int gcount[16];

    rst_n = 1'b0;
    req   = 16'hFFFF;
    @(negedge CLK);

    // reset with every request asserted
    do_reset(2);
    check("rst_gnt", 32'(gnt8), 32'h0);
    check("rst_id", 32'(id8), 32'h0);
    check("rst_token", 32'(tok8), 32'h0001);
    check("rst_state", 32'(st8), 32'(S_IDLE));

    // single requester on bit 5
    req = 16'h0020; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_gnt", 32'(gnt8), 32'h0020);
      check("single_id", 32'(id8), 32'd5);
    end
    req = 16'h0;
    tick();
    check("single_rel", 32'(gnt8), 32'h0);
    check("single_turn", 32'(st8), 32'(S_TURN));
    check("single_tok", 32'(tok8), 32'h0040);
    tick();
    check("single_idle", 32'(st8), 32'(S_IDLE));

    // rotation fairness on the no-preemption instance
    req = 16'h0;
    do_reset(1);
    exp_q.push_back(4'd0); exp_q.push_back(4'd5);
    exp_q.push_back(4'd15); exp_q.push_back(4'd0);
    base = 16'h8021;
    drop = 16'h0;
    for (int i = 0; i < 16; i++) gcount[i] = 0;
    req = base; rst_n = 1'b1; order_en = 1;
    for (int c = 0; c < 16; c++) begin
      tick();
      drop = 16'h0;
      for (int i = 0; i < 16; i++) begin
        if (gnt0[i]) gcount[i]++; else gcount[i] = 0;
        if (gcount[i] == 2) drop[i] = 1'b1;
      end
      req = base & ~drop;
    end
    order_en = 0;
    check("order_left", 32'(exp_q.size()), 32'd0);
    check("fair_tok_wrap", 32'(tok0), 32'h0002);

    // forced preemption with bits 2 and 3
    req = 16'h0;
    do_reset(1);
    req = 16'h000C; rst_n = 1'b1;
    cnt2 = 0; npre = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (gnt8 == 16'h0004) cnt2++;
      if (pre8) npre++;
    end
    check("pre_hold_cycles", 32'(cnt2), 32'd8);
    check("pre_pulses", 32'(npre), 32'd1);
    check("pre_next_owner", 32'(gnt8), 32'h0008);

    // single requester outlasting its budget
    req = 16'h0;
    do_reset(1);
    req = 16'h0080; rst_n = 1'b1;
    npre = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("solo_hold", 32'(gnt8), 32'h0080);
      if (pre8) npre++;
    end
    check("solo_no_pre", 32'(npre), 32'd0);

    // release on the timeout edge, then reset mid-grant
    req = 16'h0;
    do_reset(1);
    req = 16'h000C; rst_n = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    req = 16'h0008;
    tick();
    check("tie_pre", 32'(pre8), 32'h0);
    check("tie_gnt", 32'(gnt8), 32'h0);
    check("tie_tok", 32'(tok8), 32'h0008);
    tick();
    tick();
    check("tie_next", 32'(gnt8), 32'h0008);
    rst_n = 1'b0;
    tick();
    check("midrst_gnt", 32'(gnt8), 32'h0);
    check("midrst_tok", 32'(tok8), 32'h0001);
    check("midrst_state", 32'(st8), 32'(S_IDLE));
    rst_n = 1'b1;

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 16'($urandom_range(0, 65535));
          1: req = 16'h1 << $urandom_range(0, 15);
          2: req = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
          default: req = 16'h0;
        endcase
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
